// File: rtl/iis_pkg.sv
// Shared definitions for the I2S capture block: FSM state encoding,
// channel tag values and the default sample width.
package iis_pkg;

    localparam int DEFAULT_DW = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Word alignment FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_SHIFT = 2'd2,
        S_WAIT  = 2'd3
    } iis_state_t;

endpackage

// File: rtl/iis_sync_fifo.sv
// Single-clock FIFO with registered read data.
// Handshake: a push is accepted when not full, or when full and a pop is
// accepted in the same cycle; a pop is accepted when not empty and its data
// appears on pop_data with pop_valid high one cycle later. drop flags a push
// that was refused because the FIFO was full and nothing was popped.
module iis_sync_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         pop_valid,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // Storage array; written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers, occupancy count and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= do_pop;
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                pop_data <= mem[rptr];
                rptr     <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iis_capture.sv
// I2S (Philips format) receiver: synchronizes BCLK/LRCK/SD into pclk,
// deserializes MSB-first words one bit after each LRCK change and queues
// {channel, word} entries for the system side.
// Optional feature macro: IIS_CAPTURE_VOL_EN adds vol_l/vol_r, which hold the
// most recently completed word of each channel regardless of FIFO state.
module iis_capture
    import iis_pkg::*;
#(
    parameter int DW          = DEFAULT_DW,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          bclk_in,
    input  logic          lrck_in,
    input  logic          sd_in,
    input  logic          rdreq,
    output logic [DW-1:0] dataout,
    output logic          dout_lr,
    output logic          dvalid,
    output logic          empty,
    output logic          full,
    output logic          overrun,
    output logic          frame_err,
    input  logic          clr_err
`ifdef IIS_CAPTURE_VOL_EN
    ,
    output logic [DW-1:0] vol_l,
    output logic [DW-1:0] vol_r
`endif
);

    localparam int CNTW = $clog2(DW + 1);

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   bclk_s;
    logic                   lrck_s;
    logic                   sd_s;
    logic                   bclk_prev;
    logic                   brise;
    logic                   lrck_prev;
    logic                   lrck_edge;

    iis_state_t             state;
    iis_state_t             state_n;
    logic [CNTW-1:0]        cnt;
    logic [CNTW-1:0]        cnt_n;
    logic [DW-2:0]          shreg;
    logic [DW-2:0]          shreg_n;
    logic                   chan;
    logic                   chan_n;
    logic [DW-1:0]          word_full;
    logic                   push;
    logic                   ferr_set;
    logic                   fifo_drop;
    logic [DW:0]            fifo_rdata;

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign brise     = bclk_s & ~bclk_prev;
    assign lrck_edge = (lrck_s != lrck_prev);
    // Word as it would look with the current bit shifted in as the LSB
    assign word_full = {shreg, sd_s};

    // Input synchronizers, bclk edge history and lrck value at the last bclk rise
    always_ff @(posedge pclk) begin
        if (preset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            sd_sync   <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_in};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_in};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_in};
            bclk_prev <= bclk_s;
            if (brise) begin
                lrck_prev <= lrck_s;
            end
        end
    end

    // Alignment FSM state and datapath registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
            chan  <= CH_LEFT;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            chan  <= chan_n;
        end
    end

    // Next state: all actions happen on a bclk rise. The bit sampled on the
    // rise that shows an lrck change is the LSB of the word that is ending,
    // so a word completing on that same rise is still pushed.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        chan_n   = chan;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (brise) begin
            case (state)
                S_IDLE: begin
                    if (lrck_edge) begin
                        state_n = S_ALIGN;
                        chan_n  = lrck_s;
                        cnt_n   = '0;
                    end
                end
                S_ALIGN: begin
                    if (lrck_edge) begin
                        // A slot one bit long cannot hold a word
                        ferr_set = 1'b1;
                        chan_n   = lrck_s;
                        cnt_n    = '0;
                    end else begin
                        shreg_n = word_full[DW-2:0];
                        cnt_n   = CNTW'(1);
                        state_n = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_n = word_full[DW-2:0];
                    if (cnt == CNTW'(DW - 1)) begin
                        push    = 1'b1;
                        cnt_n   = '0;
                        state_n = lrck_edge ? S_ALIGN : S_WAIT;
                        if (lrck_edge) begin
                            chan_n = lrck_s;
                        end
                    end else if (lrck_edge) begin
                        ferr_set = 1'b1;
                        cnt_n    = '0;
                        chan_n   = lrck_s;
                        state_n  = S_ALIGN;
                    end else begin
                        cnt_n = cnt + CNTW'(1);
                    end
                end
                S_WAIT: begin
                    if (lrck_edge) begin
                        state_n = S_ALIGN;
                        chan_n  = lrck_s;
                        cnt_n   = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    iis_sync_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (pclk),
        .rst       (preset),
        .push      (push),
        .push_data ({chan, word_full}),
        .pop       (rdreq),
        .pop_data  (fifo_rdata),
        .pop_valid (dvalid),
        .full      (full),
        .empty     (empty),
        .drop      (fifo_drop)
    );

    assign dataout = fifo_rdata[DW-1:0];
    assign dout_lr = fifo_rdata[DW];

    // Sticky error flags; a new error wins over a simultaneous clear
    always_ff @(posedge pclk) begin
        if (preset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef IIS_CAPTURE_VOL_EN
    // Latest completed word per channel, updated even when the FIFO drops it
    always_ff @(posedge pclk) begin
        if (preset) begin
            vol_l <= '0;
            vol_r <= '0;
        end else if (push) begin
            if (chan == CH_LEFT) begin
                vol_l <= word_full;
            end else begin
                vol_r <= word_full;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iis_capture.sv
// Bench for iis_capture: drives I2S slots described as (channel, length, word)
// and predicts the popped samples and flags from slot-level rules.
module tb_iis_capture;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          pclk = 1'b0;
    logic          preset;
    logic          bclk_in;
    logic          lrck_in;
    logic          sd_in;
    logic          rdreq;
    logic          clr_err;
    logic [DW-1:0] dataout;
    logic          dout_lr;
    logic          dvalid;
    logic          empty;
    logic          full;
    logic          overrun;
    logic          frame_err;
`ifdef IIS_CAPTURE_VOL_EN
    logic [DW-1:0] vol_l;
    logic [DW-1:0] vol_r;
`endif

    // Clock generation: 10 ns pclk, bclk is built as 8 pclk periods
    always #5 pclk = ~pclk;

    iis_capture #(
        .DW          (DW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .bclk_in   (bclk_in),
        .lrck_in   (lrck_in),
        .sd_in     (sd_in),
        .rdreq     (rdreq),
        .dataout   (dataout),
        .dout_lr   (dout_lr),
        .dvalid    (dvalid),
        .empty     (empty),
        .full      (full),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
`ifdef IIS_CAPTURE_VOL_EN
        ,
        .vol_l     (vol_l),
        .vol_r     (vol_r)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Scenario description and scoreboard state
    int            s_len[$];
    logic          s_ch[$];
    logic [DW-1:0] s_word[$];
    logic [DW:0]   exp_q[$];
    logic          exp_over;
    logic          exp_ferr;
    logic [DW:0]   last_pop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        preset  = 1'b1;
        bclk_in = 1'b0;
        lrck_in = 1'b0;
        sd_in   = 1'b0;
        rdreq   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        exp_q.delete();
        exp_over = 1'b0;
        exp_ferr = 1'b0;
        last_pop = '0;
        s_len.delete();
        s_ch.delete();
        s_word.delete();
    endtask

    // One bclk period: data and word select change while bclk is low
    task automatic bclk_period(input logic lr, input logic d);
        bclk_in = 1'b0;
        lrck_in = lr;
        sd_in   = d;
        repeat (4) @(negedge pclk);
        bclk_in = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic add_slot(input logic ch, input int len, input logic [DW-1:0] w);
        s_ch.push_back(ch);
        s_len.push_back(len);
        s_word.push_back(w);
    endtask

    // Predict and drive all queued slots plus a one-period trailer in the
    // other channel, so the last word's LSB (sent after the lrck change) arrives.
    // A slot is captured when it starts with an lrck change (the line idles at
    // left after reset); it yields a word if it spans at least DW bit periods,
    // otherwise it is a framing error. Words beyond the FIFO depth are lost.
    task automatic play_slots();
        logic prev_bit;
        logic cur_bit;
        logic before_ch;
        prev_bit = 1'($urandom);
        for (int i = 0; i < s_len.size(); i++) begin
            before_ch = (i == 0) ? 1'b0 : s_ch[i-1];
            if (s_ch[i] != before_ch) begin
                if (s_len[i] >= DW) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({s_ch[i], s_word[i]});
                    else exp_over = 1'b1;
                end else begin
                    exp_ferr = 1'b1;
                end
            end
            for (int p = 0; p < s_len[i]; p++) begin
                cur_bit = (p < DW) ? s_word[i][DW-1-p] : 1'($urandom);
                bclk_period(s_ch[i], prev_bit);
                prev_bit = cur_bit;
            end
        end
        bclk_period(~s_ch[s_ch.size()-1], prev_bit);
        bclk_in = 1'b0;
        repeat (8) @(negedge pclk);
        s_len.delete();
        s_ch.delete();
        s_word.delete();
    endtask

    task automatic pop_check(input string tag, input logic [DW:0] e);
        rdreq = 1'b1;
        @(negedge pclk);
        rdreq = 1'b0;
        check({tag, ":dvalid"}, dvalid, 1'b1);
        check({tag, ":data"}, {dout_lr, dataout}, e);
        last_pop = e;
    endtask

    // Check flags against the model, then pop and compare every stored sample
    task automatic drain(input string tag);
        logic [DW:0] e;
        int k;
        check({tag, ":empty"}, empty, exp_q.size() == 0);
        check({tag, ":full"}, full, exp_q.size() == DEPTH);
        check({tag, ":overrun"}, overrun, exp_over);
        check({tag, ":frame_err"}, frame_err, exp_ferr);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_check($sformatf("%s:pop%0d", tag, k), e);
            k++;
        end
        check({tag, ":empty_after"}, empty, 1'b1);
    endtask

    task automatic empty_read(input string tag);
        rdreq = 1'b1;
        @(negedge pclk);
        rdreq = 1'b0;
        check({tag, ":dvalid"}, dvalid, 1'b0);
        check({tag, ":hold"}, {dout_lr, dataout}, last_pop);
    endtask

    task automatic clear_errors(input string tag);
        clr_err = 1'b1;
        @(negedge pclk);
        clr_err = 1'b0;
        check({tag, ":overrun"}, overrun, 1'b0);
        check({tag, ":frame_err"}, frame_err, 1'b0);
    endtask

    initial begin
        logic ch;
        int   n;
        int   r;
        int   len;

        // Reset state
        do_reset();
        check("rst:dataout", dataout, '0);
        check("rst:dout_lr", dout_lr, 1'b0);
        check("rst:dvalid", dvalid, 1'b0);
        check("rst:empty", empty, 1'b1);
        check("rst:full", full, 1'b0);
        check("rst:overrun", overrun, 1'b0);
        check("rst:frame_err", frame_err, 1'b0);

        // Directed words, starting mid-frame in the left channel
        do_reset();
        add_slot(1'b0, 7, 16'h1234);
        add_slot(1'b1, DW, 16'h3C5A);
        add_slot(1'b0, DW, 16'hA5C3);
        add_slot(1'b1, DW, 16'h3C5A);
        play_slots();
        drain("dir");
        empty_read("dir_er");

        // Mid-frame start with no lrck change: nothing captured
        do_reset();
        bclk_in = 1'b0;
        for (int p = 0; p < 2 * DW; p++) bclk_period(1'b0, 1'($urandom));
        repeat (8) @(negedge pclk);
        check("midframe:empty", empty, 1'b1);

        // Nine words with no pops: FIFO fills and the ninth is dropped
        do_reset();
        add_slot(1'b0, 5, '0);
        ch = 1'b1;
        for (int i = 0; i < 9; i++) begin
            add_slot(ch, DW, DW'($urandom));
            ch = ~ch;
        end
        play_slots();
        drain("ovr");
        clear_errors("ovr_clr");

        // Truncated slot: 10 bits then lrck toggles
        do_reset();
        add_slot(1'b0, 3, '0);
        add_slot(1'b1, DW, 16'hBEEF);
        add_slot(1'b0, 11, 16'hFFFF);
        add_slot(1'b1, DW, 16'h0F0F);
        add_slot(1'b0, DW, 16'h8001);
        play_slots();
        drain("trunc");
        empty_read("trunc_er");
        clear_errors("trunc_clr");

        // Reset in the middle of a word, then a clean stream
        do_reset();
        for (int p = 0; p < 5; p++) bclk_period(1'b0, 1'($urandom));
        for (int p = 0; p < 8; p++) bclk_period(1'b1, 1'($urandom));
        bclk_in = 1'b0;
        repeat (6) @(negedge pclk);
        check("midrst:empty_before", empty, 1'b1);
        do_reset();
        add_slot(1'b0, 4, '0);
        add_slot(1'b1, DW, 16'hC001);
        add_slot(1'b0, DW, 16'h5EED);
        play_slots();
        drain("midrst");

        // Randomized slot streams with short and long slots mixed in
        for (int it = 0; it < 6; it++) begin
            do_reset();
            ch = 1'($urandom);
            add_slot(ch, $urandom_range(2, 20), DW'($urandom));
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                ch = ~ch;
                r  = $urandom_range(0, 9);
                if (r < 6) len = DW;
                else if (r < 8) len = $urandom_range(2, DW - 1);
                else len = $urandom_range(DW + 1, DW + 4);
                add_slot(ch, len, DW'($urandom));
            end
            play_slots();
            drain($sformatf("rnd%0d", it));
            clear_errors($sformatf("rnd%0d_clr", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
